clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_pkg.sv | 60 ++++++
 rtl/btn_debounce.sv | 79 +++++++
 rtl/clock_set_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// -----------------------------------------------------------------------------
// clock_set_pkg
// Shared definitions for the front-panel time-setting controller:
//   - mode state encoding (RUN / SET_HOUR / SET_MIN / SET_SEC)
//   - default timing constants for the controller parameters
//   - button index constants used by the debouncer array
//   - helpers for mode sequencing and field selection
// Optional feature macro used by clock_set_ctrl: CLOCK_SET_AUTO_REPEAT_EN
// -----------------------------------------------------------------------------
package clock_set_pkg;

   // Mode state encoding, exported on mode_state.
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_SET_HOUR = 2'd1;
   localparam logic [1:0] ST_SET_MIN  = 2'd2;
   localparam logic [1:0] ST_SET_SEC  = 2'd3;

   typedef enum logic [1:0] {
      S_RUN      = ST_RUN,
      S_SET_HOUR = ST_SET_HOUR,
      S_SET_MIN  = ST_SET_MIN,
      S_SET_SEC  = ST_SET_SEC
   } state_t;

   // Default timing constants (in divided-clock cycles).
   localparam int DEF_DEBOUNCE_CYC = 2;
   localparam int DEF_TIMEOUT_CYC  = 30;
   localparam int DEF_BLINK_HALF   = 1;
   localparam int DEF_REPEAT_CYC   = 3;

   // Button indices into the conditioned-button vectors.
   localparam int BTN_MODE = 0;
   localparam int BTN_INC  = 1;
   localparam int NUM_BTN  = 2;

   // Mode button sequencing: RUN -> HOUR -> MIN -> SEC -> RUN.
   function automatic state_t next_mode(input state_t s);
      state_t n;
      case (s)
         S_RUN:      n = S_SET_HOUR;
         S_SET_HOUR: n = S_SET_MIN;
         S_SET_MIN:  n = S_SET_SEC;
         default:    n = S_RUN;
      endcase
      return n;
   endfunction

   // Field being edited, as {sec, min, hour}; all-zero in RUN.
   function automatic logic [2:0] field_sel(input state_t s);
      logic [2:0] f;
      case (s)
         S_SET_HOUR: f = 3'b001;
         S_SET_MIN:  f = 3'b010;
         S_SET_SEC:  f = 3'b100;
         default:    f = 3'b000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: two-flop synchronizer, stability counter,
// and a registered one-cycle pulse on each debounced 0->1 transition.
// A press first sampled at edge N yields press high after edge
// N + DEBOUNCE_CYC + 2. Releases produce no pulse.
//
// Ports:
//   clock   in   divided system clock
//   reset   in   synchronous active-high reset
//   btn_in  in   raw button, asynchronous to clock
//   level   out  debounced button level
//   press   out  one-cycle pulse on debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce
   import clock_set_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_in,
   output logic level,
   output logic press
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             level_dly_q, level_dly_d;
   logic             press_q, press_d;

   always_comb begin
      sync1_d     = btn_in;
      sync2_d     = sync1_q;
      cnt_d       = '0;
      level_d     = level_q;
      level_dly_d = level_q;
      // Edge detect on the accepted level, one register stage late.
      press_d     = level_q & ~level_dly_q;

      // Count only while the synced value disagrees with the accepted level;
      // any agreement (e.g. a short glitch ending) restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_dly_d;
         press_q     <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Front-panel time-setting controller for the hour/min/sec counter chain.
// The mode button steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN; the
// increment button issues one-cycle setting_* pulses for the field being set.
// An idle timeout returns to RUN and a blink strobe marks the edited field.
//
// Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN
//   When defined, holding the increment button in a SET state repeats the
//   setting pulse every REPEAT_CYC cycles after the initial press pulse.
//
// Ports:
//   clock         in   divided system clock (~3 Hz)
//   reset         in   synchronous active-high reset
//   btn_mode      in   raw mode button (asynchronous)
//   btn_inc       in   raw increment button (asynchronous)
//   load_hour     out  high while in SET_HOUR
//   load_min      out  high while in SET_MIN
//   load_sec      out  high while in SET_SEC
//   setting_hour  out  one-cycle hour increment pulse
//   setting_min   out  one-cycle minute increment pulse
//   setting_sec   out  one-cycle second increment pulse
//   mode_state    out  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   blink         out  display blank strobe for the field being set
// -----------------------------------------------------------------------------
module clock_set_ctrl
   import clock_set_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
   parameter int BLINK_HALF   = DEF_BLINK_HALF,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       load_hour,
   output logic       load_min,
   output logic       load_sec,
   output logic       setting_hour,
   output logic       setting_min,
   output logic       setting_sec,
   output logic [1:0] mode_state,
   output logic       blink
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam int               BLK_W    = $clog2(BLINK_HALF + 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

   // ---------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;

   assign btn_raw[BTN_MODE] = btn_mode;
   assign btn_raw[BTN_INC]  = btn_inc;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_btn (
            .clock  (clock),
            .reset  (reset),
            .btn_in (btn_raw[gi]),
            .level  (btn_level[gi]),
            .press  (btn_press[gi])
         );
      end
   endgenerate

   logic mode_press;
   logic inc_press;
   assign mode_press = btn_press[BTN_MODE];
   assign inc_press  = btn_press[BTN_INC];

   // ---------------------------------------------------------------------
   // FSM state and its registered side outputs
   // ---------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             blink_q, blink_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [2:0]       set_q, set_d;        // {sec, min, hour}
   logic             rpt_fire;            // auto-repeat pulse request

   // ---------------------------------------------------------------------
   // Auto-repeat
   // ---------------------------------------------------------------------
`ifdef CLOCK_SET_AUTO_REPEAT_EN
   localparam int               RPT_W    = $clog2(REPEAT_CYC + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_arm_q, rpt_arm_d;
   logic             unused_cfg;

   // Armed only by a press consumed in a SET state; a held button carried
   // across a mode change stays disarmed until it is released and pressed.
   always_comb begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
      rpt_fire  = 1'b0;
      if ((state_q != S_RUN) && !mode_press && btn_level[BTN_INC]) begin
         if (inc_press) begin
            rpt_arm_d = 1'b1;
         end else if (rpt_arm_q) begin
            rpt_arm_d = 1'b1;
            if (rpt_cnt_q == RPT_LAST) begin
               rpt_fire = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rpt_cnt_q <= '0;
         rpt_arm_q <= 1'b0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_arm_q <= rpt_arm_d;
      end
   end

   // The debounced mode level is not needed; only its press pulse is.
   assign unused_cfg = btn_level[BTN_MODE];
`else
   logic unused_cfg;

   assign rpt_fire = 1'b0;

   // Debounced levels and the repeat interval only matter with auto-repeat.
   assign unused_cfg = (^btn_level) ^ (REPEAT_CYC > 0);
`endif

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      set_d       = 3'b000;

      if (state_q == S_RUN) begin
         tmo_d       = '0;
         blink_d     = 1'b0;
         blink_cnt_d = '0;
         // inc presses are ignored in RUN.
         if (mode_press) begin
            state_d = S_SET_HOUR;
            blink_d = 1'b1;
         end
      end else if (mode_press) begin
         // Mode wins over a simultaneous inc; that inc is dropped.
         state_d     = next_mode(state_q);
         tmo_d       = '0;
         blink_d     = (next_mode(state_q) != S_RUN);
         blink_cnt_d = '0;
      end else if (inc_press || rpt_fire) begin
         // Increment the current field; restart blink phase so the new
         // value is shown immediately.
         set_d       = field_sel(state_q);
         tmo_d       = '0;
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         state_d     = S_RUN;
         tmo_d       = '0;
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
         if (blink_cnt_q == BLK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_RUN;
         tmo_q       <= '0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         set_q       <= 3'b000;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         set_q       <= set_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   logic [2:0] load_vec;
   assign load_vec = field_sel(state_q);

   assign load_hour    = load_vec[0];
   assign load_min     = load_vec[1];
   assign load_sec     = load_vec[2];
   assign setting_hour = set_q[0];
   assign setting_min  = set_q[1];
   assign setting_sec  = set_q[2];
   assign mode_state   = state_q;
   assign blink        = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl with default parameters.
// Table-driven button transactions plus directed multi-cycle sequences
// (reset, latency/blink, glitch rejection, timeout, simultaneous press,
// auto-repeat when CLOCK_SET_AUTO_REPEAT_EN is defined).
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

   localparam int DEB     = 2;
   localparam int TIMEOUT = 30;

   logic       clock;
   logic       reset;
   logic       btn_mode;
   logic       btn_inc;
   logic       load_hour, load_min, load_sec;
   logic       setting_hour, setting_min, setting_sec;
   logic [1:0] mode_state;
   logic       blink;

   clock_set_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .load_hour    (load_hour),
      .load_min     (load_min),
      .load_sec     (load_sec),
      .setting_hour (setting_hour),
      .setting_min  (setting_min),
      .setting_sec  (setting_sec),
      .mode_state   (mode_state),
      .blink        (blink)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_change = 0;
   int last_set    = 0;
   int first_set   = 0;
   int cnt_h = 0, cnt_m = 0, cnt_s = 0;
   int bad_set = 0;
   logic [1:0] prev_state = 2'd0;

   typedef struct {
      logic m;
      logic i;
      int   exp_state;
      int   exp_load;   // {sec, min, hour}
      int   exp_h;
      int   exp_m;
      int   exp_s;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge; track state changes,
   // pulse counts and load/setting consistency.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (mode_state != prev_state) last_change = cyc;
      prev_state = mode_state;
      if (setting_hour || setting_min || setting_sec) last_set = cyc;
      if (setting_hour) begin
         if (cnt_h == 0) first_set = cyc;
         cnt_h++;
      end
      if (setting_min) cnt_m++;
      if (setting_sec) cnt_s++;
      if ((setting_hour && !load_hour) || (setting_min && !load_min) ||
          (setting_sec && !load_sec))
         bad_set++;
      if (int'(load_hour) + int'(load_min) + int'(load_sec) > 1) bad_set++;
   endtask

   task automatic press_btn(input logic m, input logic i, input int hi, input int lo);
      cnt_h = 0;
      cnt_m = 0;
      cnt_s = 0;
      btn_mode = m;
      btn_inc  = i;
      repeat (hi) tick();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int e_cyc;
      int lv;

      //                 m     i     st load h  m  s
      vecs[0] = '{1'b0, 1'b1, 0, 0, 0, 0, 0};   // inc in RUN ignored
      vecs[1] = '{1'b1, 1'b0, 1, 1, 0, 0, 0};   // -> SET_HOUR
      vecs[2] = '{1'b1, 1'b0, 2, 2, 0, 0, 0};   // -> SET_MIN
      vecs[3] = '{1'b0, 1'b1, 2, 2, 0, 1, 0};
      vecs[4] = '{1'b0, 1'b1, 2, 2, 0, 1, 0};
      vecs[5] = '{1'b0, 1'b1, 2, 2, 0, 1, 0};
      vecs[6] = '{1'b1, 1'b0, 3, 4, 0, 0, 0};   // -> SET_SEC
      vecs[7] = '{1'b0, 1'b1, 3, 4, 0, 0, 1};
      vecs[8] = '{1'b1, 1'b0, 0, 0, 0, 0, 0};   // -> RUN

      // Reset held 2 cycles with both buttons high.
      reset    = 1'b1;
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      tick();
      tick();
      lv = {29'd0, load_sec, load_min, load_hour};
      check("reset_mode_state", int'(mode_state), 0);
      check("reset_load", lv, 0);
      check("reset_setting", int'({setting_sec, setting_min, setting_hour}), 0);
      check("reset_blink", int'(blink), 0);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      $display("reset: mode_state=%0d blink=%0d", mode_state, blink);

      // Fresh press latency: event after DEB+2 edges, state one edge later.
      btn_mode = 1'b1;
      n = 0;
      while (mode_state == 2'd0 && n < 20) begin
         tick();
         n++;
      end
      check("press_to_state_latency", n, DEB + 4);
      check("blink_entry", int'(blink), 1);
      tick();
      check("blink_half1", int'(blink), 0);
      tick();
      check("blink_half2", int'(blink), 1);
      $display("latency: cycles=%0d mode_state=%0d", n, mode_state);
      btn_mode = 1'b0;
      repeat (8) tick();
      check("held_no_new_event", int'(mode_state), 1);

      // Reset in the middle of SET_HOUR aborts at that edge.
      reset = 1'b1;
      tick();
      check("midset_reset_state", int'(mode_state), 0);
      check("midset_reset_load_hour", int'(load_hour), 0);
      check("midset_reset_blink", int'(blink), 0);
      reset = 1'b0;
      tick();
      $display("mid-set reset: mode_state=%0d load_hour=%0d", mode_state, load_hour);

      // Table-driven press transactions.
      for (int v = 0; v < 9; v++) begin
         press_btn(vecs[v].m, vecs[v].i, 6, 6);
         lv = {29'd0, load_sec, load_min, load_hour};
         check($sformatf("vec%0d_state", v), int'(mode_state), vecs[v].exp_state);
         check($sformatf("vec%0d_load", v), lv, vecs[v].exp_load);
         check($sformatf("vec%0d_hour_pulses", v), cnt_h, vecs[v].exp_h);
         check($sformatf("vec%0d_min_pulses", v), cnt_m, vecs[v].exp_m);
         check($sformatf("vec%0d_sec_pulses", v), cnt_s, vecs[v].exp_s);
         $display("vec %0d: mode=%0b inc=%0b -> state=%0d load=%0d pulses h/m/s=%0d/%0d/%0d",
                  v, vecs[v].m, vecs[v].i, mode_state, lv, cnt_h, cnt_m, cnt_s);
      end

      // Glitch rejection: 1-cycle spikes every 4 cycles for 40 cycles.
      n = 0;
      for (int k = 0; k < 10; k++) begin
         btn_mode = 1'b1;
         tick();
         if (mode_state != 2'd0) n++;
         btn_mode = 1'b0;
         repeat (3) begin
            tick();
            if (mode_state != 2'd0) n++;
         end
      end
      repeat (8) begin
         tick();
         if (mode_state != 2'd0) n++;
      end
      check("glitch_cycles_out_of_run", n, 0);
      check("glitch_final_state", int'(mode_state), 0);
      $display("glitch: non-RUN cycles=%0d", n);

      // Timeout from SET_SEC with no presses.
      repeat (3) press_btn(1'b1, 1'b0, 6, 6);
      check("timeout_entry_state", int'(mode_state), 3);
      e_cyc = last_change;
      n = 0;
      while (mode_state != 2'd0 && n < 80) begin
         tick();
         n++;
      end
      check("timeout_return_cycle", cyc - e_cyc, TIMEOUT);
      $display("timeout: returned after %0d cycles", cyc - e_cyc);

      // Timeout deferred by an inc event 20 cycles into SET_SEC.
      repeat (3) press_btn(1'b1, 1'b0, 6, 6);
      e_cyc = last_change;
      while (cyc < e_cyc + 14) tick();
      press_btn(1'b0, 1'b1, 6, 6);
      check("deferred_inc_cycle", last_set - e_cyc, 20);
      check("deferred_sec_pulses", cnt_s, 1);
      n = 0;
      while (mode_state != 2'd0 && n < 80) begin
         tick();
         n++;
      end
      check("timeout_deferred_cycle", cyc - e_cyc, 20 + TIMEOUT);
      $display("timeout deferred: inc at %0d, returned at %0d", last_set - e_cyc, cyc - e_cyc);

      // Simultaneous mode + inc in SET_HOUR: mode wins.
      press_btn(1'b1, 1'b0, 6, 6);
      press_btn(1'b1, 1'b1, 6, 6);
      check("simul_state", int'(mode_state), 2);
      check("simul_hour_pulses", cnt_h, 0);
      check("simul_min_pulses", cnt_m, 0);
      $display("simultaneous: state=%0d hour pulses=%0d", mode_state, cnt_h);

      // Held inc in SET_HOUR (SET_MIN -> SET_SEC -> RUN -> SET_HOUR).
      repeat (3) press_btn(1'b1, 1'b0, 6, 6);
      check("hold_entry_state", int'(mode_state), 1);
      press_btn(1'b0, 1'b1, 12, 8);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      check("repeat_pulse_count", cnt_h, 4);
      check("repeat_span", last_set - first_set, 9);
`else
      check("hold_pulse_count", cnt_h, 1);
`endif
      check("hold_state", int'(mode_state), 1);
      $display("hold inc: hour pulses=%0d", cnt_h);

      check("load_setting_consistency", bad_set, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
